// File: rtl/fwd_pkg.sv
// Shared types and constants for the write-back forwarding unit.
// Widths of hist_entry_t match the default datapath configuration.
package fwd_pkg;

  localparam int FWD_CNT_W  = 16;
  localparam int ZERO_REG   = 0;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } hist_entry_t;

endpackage

// File: rtl/fwd_lookup.sv
// Single read-port priority mux: live write-back first, then history
// entries from newest (0) to oldest (DEPTH-1), else the raw register file value.
module fwd_lookup
  import fwd_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic                    blank,
  input  logic                    wbWe,
  input  logic [ADDR_W-1:0]       wbAddr,
  input  logic [DATA_W-1:0]       wbData,
  input  logic [DEPTH-1:0]        histValid,
  input  logic [DEPTH*ADDR_W-1:0] histAddr,
  input  logic [DEPTH*DATA_W-1:0] histData,
  input  logic [ADDR_W-1:0]       rdAddr,
  input  logic [DATA_W-1:0]       rdDataIn,
  output logic [DATA_W-1:0]       rdDataOut,
  output logic                    fwdHit
);

  // Walk history oldest-to-newest so a newer match overrides an older one.
  always_comb begin
    rdDataOut = rdDataIn;
    fwdHit    = 1'b0;
    if (!blank && (rdAddr != ADDR_W'(ZERO_REG))) begin
      if (wbWe && (wbAddr == rdAddr)) begin
        rdDataOut = wbData;
        fwdHit    = 1'b1;
      end else begin
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (histValid[i] && (histAddr[i*ADDR_W +: ADDR_W] == rdAddr)) begin
            rdDataOut = histData[i*DATA_W +: DATA_W];
            fwdHit    = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/wb_forward_history.sv
// Write-back bypass: selects the MEM/WB result, forwards it to every read port,
// and keeps a short history of retired writes for reads racing the register file.
module wb_forward_history
  import fwd_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = 2,
  parameter int NUM_PORTS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_we,
  input  logic [ADDR_W-1:0]           wb_addr,
  input  logic                        wb_jal,
  input  logic                        wb_mem_to_reg,
  input  logic [DATA_W-1:0]           wb_alu_result,
  input  logic [DATA_W-1:0]           wb_pc_next,
  input  logic [DATA_W-1:0]           wb_mem_data,
  input  logic                        hold,
  input  logic                        flush,
  input  logic [NUM_PORTS*ADDR_W-1:0] rd_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] rd_data_in,
  output logic [NUM_PORTS*DATA_W-1:0] rd_data_out,
  output logic [NUM_PORTS-1:0]        rd_fwd_hit,
  output logic [DATA_W-1:0]           wb_result,
  output logic [FWD_CNT_W-1:0]        fwd_count
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } histEntry_t;

  histEntry_t              hist [DEPTH];
  logic                    newValid;
  logic [DEPTH-1:0]        histValid;
  logic [DEPTH*ADDR_W-1:0] histAddr;
  logic [DEPTH*DATA_W-1:0] histData;

  assign wb_result = wb_jal        ? wb_pc_next  :
                     wb_mem_to_reg ? wb_mem_data : wb_alu_result;
  assign newValid  = wb_we && (wb_addr != ADDR_W'(ZERO_REG));

  // Flush clears validity even while held; a held flush captures nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      fwd_count <= '0;
    end else begin
      if (!hold) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          hist[i] <= hist[i-1];
          if (flush) hist[i].valid <= 1'b0;
        end
        hist[0] <= {newValid, wb_addr, wb_result};
      end else if (flush) begin
        for (int i = 0; i < DEPTH; i++) hist[i].valid <= 1'b0;
      end
      if (!hold && (|rd_fwd_hit) && (fwd_count != {FWD_CNT_W{1'b1}})) begin
        fwd_count <= fwd_count + 1'b1;
      end
    end
  end

  always_comb begin
    histValid = '0;
    histAddr  = '0;
    histData  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      histValid[i]                  = hist[i].valid;
      histAddr[i*ADDR_W +: ADDR_W]  = hist[i].addr;
      histData[i*DATA_W +: DATA_W]  = hist[i].data;
    end
  end

  for (genvar k = 0; k < NUM_PORTS; k++) begin : gPort
    fwd_lookup #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) uLookup (
      .blank     (rst),
      .wbWe      (wb_we),
      .wbAddr    (wb_addr),
      .wbData    (wb_result),
      .histValid (histValid),
      .histAddr  (histAddr),
      .histData  (histData),
      .rdAddr    (rd_addr[k*ADDR_W +: ADDR_W]),
      .rdDataIn  (rd_data_in[k*DATA_W +: DATA_W]),
      .rdDataOut (rd_data_out[k*DATA_W +: DATA_W]),
      .fwdHit    (rd_fwd_hit[k])
    );
  end

endmodule

// File: tb/tb_wb_forward_history.sv
// Directed bench for wb_forward_history with hand-computed expectations
// and a saturating model of the forward-hit counter.
module tb_wb_forward_history;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we, wb_jal, wb_mem_to_reg, hold, flush;
  logic [3:0]  wb_addr;
  logic [15:0] wb_alu_result, wb_pc_next, wb_mem_data;
  logic [3:0]  rdAddr1, rdAddr2;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data_in;
  logic [31:0] rd_data_out;
  logic [1:0]  rd_fwd_hit;
  logic [15:0] wb_result, fwd_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] expCount = 16'h0000;

  assign rd_addr    = {rdAddr2, rdAddr1};
  assign rd_data_in = {16'h6666, 16'h5555};

  always #5 clk = ~clk;

  wb_forward_history dut (
    .clk           (clk),
    .rst           (rst),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_jal        (wb_jal),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_alu_result (wb_alu_result),
    .wb_pc_next    (wb_pc_next),
    .wb_mem_data   (wb_mem_data),
    .hold          (hold),
    .flush         (flush),
    .rd_addr       (rd_addr),
    .rd_data_in    (rd_data_in),
    .rd_data_out   (rd_data_out),
    .rd_fwd_hit    (rd_fwd_hit),
    .wb_result     (wb_result),
    .fwd_count     (fwd_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] addr, input logic jal,
                               input logic m2r, input logic [15:0] alu);
    wb_we         = we;
    wb_addr       = addr;
    wb_jal        = jal;
    wb_mem_to_reg = m2r;
    wb_alu_result = alu;
  endtask

  // expHit is the hand-computed "any port hits" state at this edge.
  task automatic clockEdge(input bit expHit);
    @(posedge clk);
    if (expHit && !hold && expCount != 16'hFFFF) expCount = expCount + 16'h1;
    #1;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    wb_pc_next = 16'h0000; wb_mem_data = 16'h0000;
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 16'h1234);
    rdAddr1 = 4'd3; rdAddr2 = 4'd9;
    #3;
    checkOutput("reset_hit", 32'(rd_fwd_hit), 32'h0);
    checkOutput("reset_out", rd_data_out, 32'h6666_5555);
    checkOutput("reset_count", 32'(fwd_count), 32'h0);
    checkOutput("reset_wbres", 32'(wb_result), 32'h1234);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // live write-back forward
    checkOutput("live_out", rd_data_out, 32'h6666_1234);
    checkOutput("live_hit", 32'(rd_fwd_hit), 32'h1);
    clockEdge(1'b1);

    // jal write then history aging
    wb_pc_next = 16'h0042;
    applyStimulus(1'b1, 4'd7, 1'b1, 1'b0, 16'h0BAD);
    rdAddr1 = 4'd7;
    #1;
    checkOutput("jal_wbres", 32'(wb_result), 32'h0042);
    checkOutput("jal_live", rd_data_out, 32'h6666_0042);
    clockEdge(1'b1);
    applyStimulus(1'b0, 4'd7, 1'b0, 1'b0, 16'h0BAD);
    rdAddr2 = 4'd3;
    #1;
    checkOutput("jal_entry0", rd_data_out, 32'h1234_0042);
    checkOutput("jal_entry0_hit", 32'(rd_fwd_hit), 32'h3);
    clockEdge(1'b1);
    rdAddr2 = 4'd9;
    #1;
    checkOutput("jal_entry1", rd_data_out, 32'h6666_0042);
    clockEdge(1'b1);
    checkOutput("jal_aged_out", rd_data_out, 32'h6666_5555);
    checkOutput("jal_aged_hit", 32'(rd_fwd_hit), 32'h0);
    clockEdge(1'b0);
    checkOutput("count_a", 32'(fwd_count), 32'(expCount));

    // newest value wins
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 16'hAAAA);
    rdAddr1 = 4'd2;
    clockEdge(1'b1);
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 16'hBBBB);
    clockEdge(1'b1);
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 16'hCCCC);
    #1;
    checkOutput("dup_live", rd_data_out, 32'h6666_CCCC);
    wb_we = 1'b0;
    #1;
    checkOutput("dup_hist", rd_data_out, 32'h6666_BBBB);
    clockEdge(1'b1);

    // register zero is never forwarded nor captured
    wb_mem_data = 16'hFFFF;
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b1, 16'h0F0F);
    rdAddr1 = 4'd0;
    #1;
    checkOutput("r0_out", rd_data_out, 32'h6666_5555);
    checkOutput("r0_hit", 32'(rd_fwd_hit), 32'h0);
    checkOutput("r0_wbres", 32'(wb_result), 32'hFFFF);
    clockEdge(1'b0);
    wb_we = 1'b0;
    #1;
    checkOutput("r0_nocapture", 32'(rd_fwd_hit), 32'h0);

    // fill, hold, then flush with a retiring write
    applyStimulus(1'b1, 4'd4, 1'b0, 1'b0, 16'h4444);
    rdAddr1 = 4'd4;
    clockEdge(1'b1);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 16'h5A5A);
    clockEdge(1'b1);
    rdAddr2 = 4'd5;
    hold = 1'b1;
    applyStimulus(1'b1, 4'd6, 1'b0, 1'b0, 16'h6060);
    clockEdge(1'b1);
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 16'h1010);
    clockEdge(1'b1);
    applyStimulus(1'b0, 4'd6, 1'b0, 1'b0, 16'h7070);
    clockEdge(1'b1);
    checkOutput("hold_hist", rd_data_out, 32'h5A5A_4444);
    checkOutput("hold_count", 32'(fwd_count), 32'(expCount));
    hold = 1'b0; flush = 1'b1;
    applyStimulus(1'b1, 4'd8, 1'b0, 1'b0, 16'h8888);
    clockEdge(1'b1);
    flush = 1'b0; wb_we = 1'b0;
    #1;
    checkOutput("flush_miss_hit", 32'(rd_fwd_hit), 32'h0);
    rdAddr2 = 4'd8;
    #1;
    checkOutput("flush_capture", rd_data_out, 32'h8888_5555);

    // saturate the counter
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 16'h3333);
    rdAddr1 = 4'd3;
    while (expCount != 16'hFFFE) clockEdge(1'b1);
    checkOutput("count_fffe", 32'(fwd_count), 32'hFFFE);
    for (int i = 0; i < 3; i++) clockEdge(1'b1);
    checkOutput("count_sat", 32'(fwd_count), 32'hFFFF);

    // asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_count", 32'(fwd_count), 32'h0);
    checkOutput("arst_hit", 32'(rd_fwd_hit), 32'h0);
    checkOutput("arst_out", rd_data_out, 32'h6666_5555);
    @(negedge clk);
    rst = 1'b0;
    expCount = 16'h0;
    clockEdge(1'b1);
    wb_we = 1'b0;
    rdAddr2 = 4'd9;
    #1;
    checkOutput("post_rst_capture", rd_data_out, 32'h6666_3333);
    checkOutput("post_rst_count", 32'(fwd_count), 32'(expCount));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
